// File: rtl/cpu_mem_arbiter_if.sv
// cpu_mem_arbiter_if: one SRAM-like request/response channel.
// The master issues requests and receives handshakes and responses.
// The slave accepts requests and returns handshakes and responses.
interface cpu_mem_arbiter_if;
  logic        req;
  logic        wr;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: merges the instruction-fetch and data channels onto one
// shared SRAM-like memory port. An in-order ID FIFO routes each response back
// to the channel that issued the request. The request and response paths are
// both purely combinational.
// Optional macro CPU_MEM_ARB_RR_EN selects round-robin arbitration on
// contention. The default is fixed data-over-inst priority.
module cpu_mem_arbiter #(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  cpu_mem_arbiter_if.slave  inst,
  cpu_mem_arbiter_if.slave  data,
  cpu_mem_arbiter_if.master mem
);
  localparam int unsigned   AW      = $clog2(DEPTH);
  localparam int unsigned   CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic          ID_INST = 1'b0;
  localparam logic          ID_DATA = 1'b1;

  // The hold states freeze the grant while a presented request waits for
  // mem.addr_ok.
  typedef enum logic [1:0] {
    ARB_OPEN,
    ARB_HOLD_INST,
    ARB_HOLD_DATA
  } arb_state_e;

  arb_state_e       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [DEPTH-1:0] fifo_q, fifo_d;

  logic grant_data;
  logic granted_req;
  logic accept;
  logic pop;
  logic head;
  logic unused_inst_fields;

`ifdef CPU_MEM_ARB_RR_EN
  logic last_q, last_d;
`endif

  // Grant selection: a held grant wins. Otherwise the contention rule decides.
  always_comb begin
    grant_data = ID_INST;
    case (state_q)
      ARB_HOLD_INST: grant_data = ID_INST;
      ARB_HOLD_DATA: grant_data = ID_DATA;
      default: begin
`ifdef CPU_MEM_ARB_RR_EN
        if (inst.req && data.req) grant_data = (last_q == ID_INST);
        else                      grant_data = data.req;
`else
        grant_data = data.req;
`endif
      end
    endcase
  end

  // Request path: mux the granted channel onto the shared port and gate it on FIFO space.
  always_comb begin
    granted_req = grant_data ? data.req : inst.req;
    mem.req     = resetn && granted_req && (count_q != FULL);
    mem.wr      = grant_data ? data.wr    : 1'b0;
    mem.wstrb   = grant_data ? data.wstrb : '0;
    mem.addr    = grant_data ? data.addr  : inst.addr;
    mem.wdata   = grant_data ? data.wdata : '0;
    accept      = mem.req && mem.addr_ok;
    inst.addr_ok = accept && (grant_data == ID_INST);
    data.addr_ok = accept && (grant_data == ID_DATA);
  end

  // Response path: the FIFO head names the owner. A response while empty is dropped.
  always_comb begin
    pop          = resetn && mem.data_ok && (count_q != '0);
    head         = fifo_q[rptr_q];
    inst.data_ok = pop && (head == ID_INST);
    data.data_ok = pop && (head == ID_DATA);
    inst.rdata   = mem.rdata;
    data.rdata   = mem.rdata;
  end

  // The inst channel is read-only, so its write fields are not used.
  assign unused_inst_fields = ^{inst.wr, inst.wstrb, inst.wdata};

  // Next state for the grant hold, the ID FIFO and the occupancy count.
  always_comb begin
    state_d = state_q;
    fifo_d  = fifo_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;

    if (mem.req && !mem.addr_ok) state_d = grant_data ? ARB_HOLD_DATA : ARB_HOLD_INST;
    else if (accept)             state_d = ARB_OPEN;

    if (accept) begin
      fifo_d[wptr_q] = grant_data;
      wptr_d         = wptr_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;

    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

`ifdef CPU_MEM_ARB_RR_EN
  // The last-winner register follows every accept.
  always_comb begin
    last_d = accept ? grant_data : last_q;
  end
`endif

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ARB_OPEN;
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      fifo_q  <= '0;
`ifdef CPU_MEM_ARB_RR_EN
      last_q  <= ID_INST;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      fifo_q  <= fifo_d;
`ifdef CPU_MEM_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

endmodule
